// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues program-ROM requests and
// buffers fetched words with their addresses in a DEPTH-entry prefetch queue.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 11,
  parameter int unsigned           IR_WIDTH     = 24,
  parameter int unsigned           DEPTH        = 4,
  parameter int unsigned           OFFSET_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IR_WIDTH-1:0]     rom_out,
  input  logic                    rom_ready,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_active,
  output logic [IR_WIDTH-1:0]     ir_out,
  output logic [ADDR_WIDTH-1:0]   ir_pc,
  output logic                    ir_valid,
  input  logic                    ir_ready,
  input  logic                    redirect,
  input  logic                    redirect_abs,
  input  logic [OFFSET_WIDTH-1:0] redirect_offset,
  input  logic [ADDR_WIDTH-1:0]   redirect_target,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned LVL_WIDTH = PTR_WIDTH + 1;
  localparam logic [LVL_WIDTH-1:0]  FULL = LVL_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  fa, fa_next, addr_next, target;
  logic [IR_WIDTH-1:0]    data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [PTR_WIDTH-1:0]   rd_ptr, wr_ptr;
  logic [LVL_WIDTH-1:0]   level_after_pop;
  logic                   flush, pop, push;

  assign ir_valid = (level != '0);
  assign ir_out   = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? pc_mem[rd_ptr]   : '0;

  // A relative redirect needs a valid head to be relative to; otherwise it is dropped.
  assign flush  = redirect & (redirect_abs | ir_valid);
  assign target = redirect_abs ? redirect_target
                               : ir_pc + ONE + ADDR_WIDTH'(signed'(redirect_offset));
  assign pop    = ir_ready & ir_valid & ~flush;
  assign level_after_pop = level - LVL_WIDTH'(pop);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    fa_next    = fa;
    addr_next  = rom_addr;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fa_next = target;
        end else if (level_after_pop < FULL) begin
          state_next = FETCH;
          addr_next  = fa;
          fa_next    = fa + ONE;
        end
      end
      FETCH: begin
        if (flush) begin
          fa_next    = target;
          state_next = DISCARD;
        end else if (rom_ready) begin
          push = 1'b1;
          if (level_after_pop + LVL_WIDTH'(1) < FULL) begin
            addr_next = fa;
            fa_next   = fa + ONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (flush)     fa_next    = target;
        if (rom_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fa         <= RESET_PC;
      rom_addr   <= RESET_PC;
      rom_active <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
    end else begin
      state      <= state_next;
      fa         <= fa_next;
      rom_addr   <= addr_next;
      rom_active <= (state_next != IDLE);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        level <= level_after_pop + LVL_WIDTH'(push);
      end
    end
  end

  // NOTE: queue storage is not reset; ir_valid gates the head outputs, so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= rom_out;
      pc_mem[wr_ptr]   <= rom_addr;
    end
  end

endmodule
